// File: rtl/ifft_frame_loader_pkg.sv
// Shared pitch-shifter definitions for the IFFT frame loader.
// Holds the default frame geometry and the loader state encoding.
//   IFL_N_BINS     : bins per frame (power of two)
//   IFL_DATA_WIDTH : complex bin width, imag [79:40], real [39:0]
//   IFL_K_WIDTH    : bin index width, log2(IFL_N_BINS)
package ifft_frame_loader_pkg;

    localparam int unsigned IFL_N_BINS     = 2048;
    localparam int unsigned IFL_DATA_WIDTH = 80;
    localparam int unsigned IFL_K_WIDTH    = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } ifl_state_t;

endpackage

// File: rtl/ifft_frame_loader_frame_ram.sv
// frame_ram: simple dual-port frame memory, one write port and one
// synchronous read port (1-cycle latency), written to infer block RAM.
//   clock   : sole clock
//   wr_en   : write strobe, wr_addr/wr_data qualified
//   rd_en   : read strobe, rd_data updates on the following edge
//   rd_data : registered read data (no reset, block RAM style)
module frame_ram #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 80,
    parameter int unsigned AW    = 11
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ifft_frame_loader.sv
// ifft_frame_loader: collects resampled bins (any order, indexed by in_k)
// into a frame memory, then streams the frame to the IFFT over AXI-Stream
// in natural order 0..N_BINS-1.
//   clock, reset_n          : clock, asynchronous active-low reset
//   in_data/in_k/in_valid/in_last, in_ready : resampler side
//   m_tdata/m_tvalid/m_tlast, m_tready      : AXI-Stream master to IFFT
//   err_overrun : input arrived while draining (sticky)
//   err_short   : frame ended with fewer than N_BINS accepted bins (sticky)
module ifft_frame_loader
    import ifft_frame_loader_pkg::*;
#(
    parameter int unsigned N_BINS     = IFL_N_BINS,
    parameter int unsigned DATA_WIDTH = IFL_DATA_WIDTH,
    parameter int unsigned K_WIDTH    = IFL_K_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [K_WIDTH-1:0]    in_k,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  err_overrun,
    output logic                  err_short
);

    localparam logic [K_WIDTH:0]   FRAME_LEN = (K_WIDTH+1)'(N_BINS);
    localparam logic [K_WIDTH-1:0] LAST_K    = K_WIDTH'(N_BINS - 1);

    ifl_state_t            state, state_nxt;
    logic                  ready_en;
    logic [K_WIDTH:0]      wr_cnt, wr_cnt_inc;
    logic                  accept, pop, issue;
    logic [K_WIDTH-1:0]    rd_addr;
    logic                  rd_done, rd_pend, rd_pend_last;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] slot0, slot1;
    logic                  last0, last1;
    logic [1:0]            count;
    logic [2:0]            occ;

    frame_ram #(
        .DEPTH (N_BINS),
        .WIDTH (DATA_WIDTH),
        .AW    (K_WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (accept),
        .wr_addr (in_k),
        .wr_data (in_data),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign m_tdata  = slot0;
    assign m_tvalid = (count != 2'd0);
    assign m_tlast  = m_tvalid && last0;

    always_comb begin
        in_ready   = ready_en && (state != ST_DRAIN);
        accept     = in_valid && in_ready;
        pop        = m_tvalid && m_tready;
        wr_cnt_inc = wr_cnt + 1'b1;
        // Entries held plus the read in flight, less the beat leaving now;
        // a new read is issued only if its data is guaranteed a slot.
        occ        = 3'(count) + 3'(rd_pend) - 3'(pop);
        issue      = (state == ST_DRAIN) && !rd_done && (occ < 3'd2);
        state_nxt  = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = in_last ? ST_DRAIN : ST_FILL;
            ST_FILL:  if (accept && in_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (pop && m_tlast) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            ready_en    <= 1'b0;
            wr_cnt      <= '0;
            err_overrun <= 1'b0;
            err_short   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ready_en <= 1'b1;
            if (state == ST_DRAIN && state_nxt == ST_IDLE) begin
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt_inc;
            end
            if (accept && in_last && wr_cnt_inc != FRAME_LEN) begin
                err_short <= 1'b1;
            end
            if (state == ST_DRAIN && in_valid) begin
                err_overrun <= 1'b1;
            end
        end
    end

    // Read sequencer: stops after LAST_K so no bin is fetched twice.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr      <= '0;
            rd_done      <= 1'b0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
        end else begin
            rd_pend      <= issue;
            rd_pend_last <= issue && (rd_addr == LAST_K);
            if (state != ST_DRAIN) begin
                rd_addr <= '0;
                rd_done <= 1'b0;
            end else if (issue) begin
                if (rd_addr == LAST_K) begin
                    rd_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    // Two-entry skid: slot0 is the presented beat, slot1 catches the
    // in-flight read when the IFFT stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            case ({pop, rd_pend})
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= rd_data;
                        last0 <= rd_pend_last;
                    end else begin
                        slot0 <= slot1;
                        last0 <= last1;
                        slot1 <= rd_data;
                        last1 <= rd_pend_last;
                    end
                end
                2'b10: begin
                    slot0 <= slot1;
                    last0 <= last1;
                    count <= count - 1'b1;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        slot0 <= rd_data;
                        last0 <= rd_pend_last;
                    end else begin
                        slot1 <= rd_data;
                        last1 <= rd_pend_last;
                    end
                    count <= count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft_frame_loader.sv
// Self-checking bench for ifft_frame_loader: a memory model plus a
// scoreboard queue of expected beats, filled at each in_last and drained
// by an output monitor.
module tb_ifft_frame_loader;
    import ifft_frame_loader_pkg::*;

    localparam int unsigned NB = 2048;
    localparam int unsigned DW = 80;
    localparam int unsigned KW = 11;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic [KW-1:0] in_k;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          err_overrun;
    logic          err_short;

    ifft_frame_loader #(
        .N_BINS     (NB),
        .DATA_WIDTH (DW),
        .K_WIDTH    (KW)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_k        (in_k),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .err_overrun (err_overrun),
        .err_short   (err_short)
    );

    always #5 clock = ~clock;

    int            errors = 0;
    int            checks = 0;
    beat_t         sb[$];
    logic [DW-1:0] model [NB];
    int            beat_idx    = 0;
    int            frames_done = 0;
    int            rdy_mode    = 0;
    int            stall_n     = 0;
    int            cyc         = 0;
    bit            stall_prev  = 1'b0;
    bit            post_last   = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int k, input int salt);
        logic [39:0] re, im;
        re = 40'(k + salt);
        im = 40'(k ^ salt);
        return {im, re};
    endfunction

    // Output monitor: scoreboard compare, stall stability, in_ready rules.
    always @(negedge clock) begin
        beat_t e;
        if (!reset_n) begin
            stall_prev = 1'b0;
            post_last  = 1'b0;
            beat_idx   = 0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, prev_data);
                check("stall_last", m_tlast, prev_last);
            end
            if (post_last) begin
                check("ready_after_last", in_ready, 1);
                post_last = 1'b0;
            end
            if (m_tvalid) check("ready_in_drain", in_ready, 0);
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", m_tdata, e.data);
                    check("beat_last", m_tlast, e.last);
                end
                beat_idx++;
                if (m_tlast) begin
                    post_last = 1'b1;
                    beat_idx  = 0;
                    frames_done++;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    // Sink ready pattern: 0 = always ready, 1 = toggle with a 10-cycle
    // stall once beat 1000 is reached.
    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clock); #1;
            cyc++;
            if (rdy_mode == 0) begin
                m_tready = 1'b1;
            end else if (beat_idx >= 1000 && stall_n < 10) begin
                m_tready = 1'b0;
                stall_n++;
            end else begin
                m_tready = cyc[0];
            end
        end
    end

    // Called at posedge+1; returns at posedge+1.
    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
        sb.delete();
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err_overrun", err_overrun, 0);
        check("rst_err_short", err_short, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", in_ready, 0);
        @(posedge clock); #1;
        check("ready_after_release", in_ready, 1);
    endtask

    // Sends bins 0..n_send-1, last on n_send-1, then queues the full
    // expected frame and checks first-beat latency.
    task automatic send_frame(input int n_send, input int salt);
        beat_t e;
        for (int k = 0; k < n_send; k++) begin
            check("fill_ready", in_ready, 1);
            in_valid = 1'b1;
            in_k     = KW'(k);
            in_data  = mk_data(k, salt);
            in_last  = (k == n_send - 1);
            model[k] = in_data;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < int'(NB); k++) begin
            e.data = model[k];
            e.last = (k == int'(NB) - 1);
            sb.push_back(e);
        end
        @(negedge clock);
        check("lat_cycle0", m_tvalid, 0);
        @(negedge clock);
        check("lat_cycle1", m_tvalid, 0);
        @(negedge clock);
        check("lat_cycle2", m_tvalid, 1);
        @(posedge clock); #1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) begin
            @(posedge clock); #1;
        end
        check("frame_complete", frames_done >= target, 1);
        check("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        reset_n  = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_k     = '0;
        in_data  = '0;
        #2;
        do_reset();

        // Full frame {k,k}, followed back-to-back by a second frame.
        rdy_mode = 0;
        send_frame(NB, 0);
        wait_frames(1, 5000);
        send_frame(NB, 'h155);
        wait_frames(2, 5000);
        check("err_overrun_clean", err_overrun, 0);
        check("err_short_clean", err_short, 0);

        // Backpressure: toggling ready plus a long stall.
        rdy_mode = 1;
        stall_n  = 0;
        send_frame(NB, 'h2aa);
        wait_frames(3, 10000);
        rdy_mode = 0;
        check("err_short_bp", err_short, 0);

        // Short frame: bin NB-1 keeps the previous frame's value.
        send_frame(NB - 1, 'h3c3);
        wait_frames(4, 5000);
        check("err_short_set", err_short, 1);
        check("err_overrun_after_short", err_overrun, 0);

        // Overrun: stray k=5 write during drain must be discarded.
        send_frame(NB, 'h5a5);
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_k     = KW'(5);
        in_data  = {DW{1'b1}};
        @(posedge clock); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        wait_frames(5, 5000);
        check("err_overrun_set", err_overrun, 1);
        check("err_short_sticky", err_short, 1);

        // Reset in the middle of a drain, then a clean frame.
        send_frame(NB, 'h0f0);
        for (int i = 0; i < 1000 && beat_idx < 300; i++) begin
            @(posedge clock); #1;
        end
        check("reached_beat300", beat_idx >= 300, 1);
        do_reset();
        send_frame(NB, 'h777);
        wait_frames(6, 5000);
        check("err_overrun_final", err_overrun, 0);
        check("err_short_final", err_short, 0);

        repeat (5) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
